// File: rtl/ltc2308_responder.sv
// ltc2308_responder: clocked LTC2308 ADC-side emulation (CONVST/SCK/SDI in, SDO out, 6-bit config decode)
// Ports: clk, reset (sync, active-high); convst/sck/sdi async bus inputs; sdo serial sample out;
//        ch_data parallel bank (channel n at [n*12 +: 12]); busy during conversion;
//        cfg_valid/cfg_word for each complete config word; frame_done after the 12th SCK rise.
module ltc2308_responder #(
  parameter int NUM_CH       = 8,
  parameter int TCONV_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   convst,
  input  logic                   sck,
  input  logic                   sdi,
  output logic                   sdo,
  input  logic [NUM_CH*12-1:0]   ch_data,
  output logic                   busy,
  output logic                   cfg_valid,
  output logic [5:0]             cfg_word,
  output logic                   frame_done
);
  typedef enum logic [1:0] {IDLE, CONV, SHIFT} state_t;
  state_t state, state_n;
  logic [2:0] cv_q, sck_q;
  logic [1:0] sdi_q;
  logic [11:0] shreg, sample;
  logic [7:0] tconv;
  logic [3:0] bitcnt;
  logic [2:0] cfgcnt, cur_ch;
  logic [4:0] cfg_sr;
  logic cv_rise, sck_rise, sck_fall, start;
  always_ff @(posedge clk) begin
    if (reset) begin
      cv_q  <= '0;
      sck_q <= '0;
      sdi_q <= '0;
    end else begin
      cv_q  <= {cv_q[1:0], convst};
      sck_q <= {sck_q[1:0], sck};
      sdi_q <= {sdi_q[0], sdi};
    end
  end
  assign cv_rise  = cv_q[1] & ~cv_q[2];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  // A CONVST rise restarts from IDLE or aborts a frame in SHIFT; only CONV ignores it.
  assign start = cv_rise && state != CONV;
  always_comb begin
    sample = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (32'(cur_ch) == i) sample = ch_data[i*12 +: 12];
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = start                                           ? CONV  :
              (state == CONV && tconv == 8'd1)                ? SHIFT :
              (state == SHIFT && sck_rise && bitcnt == 4'd11) ? IDLE  : state;
  end
  always_comb begin
    busy = state == CONV;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sdo        <= 1'b0;
      shreg      <= '0;
      tconv      <= '0;
      bitcnt     <= '0;
      cfgcnt     <= '0;
      cfg_sr     <= '0;
      cfg_word   <= '0;
      cur_ch     <= '0;
      cfg_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cfg_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (start) begin
        // UNI=0 selects bipolar: flip MSB to turn offset-binary into two's complement
        shreg  <= {sample[11] ^ ~cfg_word[1], sample[10:0]};
        tconv  <= 8'(TCONV_CYCLES);
        bitcnt <= '0;
        cfgcnt <= '0;
        sdo    <= 1'b0;
      end else if (state == CONV) begin
        tconv <= tconv - 8'd1;
        if (tconv == 8'd1) sdo <= shreg[11];
      end else if (state == SHIFT) begin
        if (sck_rise) begin
          bitcnt <= bitcnt + 4'd1;
          if (cfgcnt < 3'd6) begin
            cfg_sr <= {cfg_sr[3:0], sdi_q[1]};
            cfgcnt <= cfgcnt + 3'd1;
          end
          // Sixth bit completes {S/D,O/S,S1,S0,UNI,SLP}; channel is {S1,S0,O/S}
          if (cfgcnt == 3'd5) begin
            cfg_word  <= {cfg_sr, sdi_q[1]};
            cur_ch    <= {cfg_sr[2], cfg_sr[1], cfg_sr[3]};
            cfg_valid <= 1'b1;
          end
          if (bitcnt == 4'd11) begin
            frame_done <= 1'b1;
            sdo        <= 1'b0;
          end
        end else if (sck_fall && bitcnt != 4'd0 && bitcnt < 4'd12) begin
          shreg <= {shreg[10:0], 1'b0};
          sdo   <= shreg[10];
        end
      end
    end
  end
endmodule

// File: tb/tb_ltc2308_responder.sv
// tb_ltc2308_responder: scoreboard bench driving the ADC bus as a master
module tb_ltc2308_responder;
  localparam int NUM_CH = 8;
  localparam int T      = 64;
  logic clk = 1'b0, reset = 1'b1, convst = 1'b0, sck = 1'b0, sdi = 1'b0;
  logic sdo, busy, cfg_valid, frame_done;
  logic [5:0] cfg_word;
  logic [NUM_CH*12-1:0] ch_data = '0;
  logic [11:0] cap = '0;
  logic [11:0] exp_q[$];
  logic [5:0]  cfg_q[$];
  int checks = 0, failures = 0, frames = 0, frames_exp = 0;
  ltc2308_responder #(.NUM_CH(NUM_CH), .TCONV_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .convst(convst), .sck(sck), .sdi(sdi), .sdo(sdo),
    .ch_data(ch_data), .busy(busy), .cfg_valid(cfg_valid), .cfg_word(cfg_word),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  // Master-side receiver: sdo sampled at each SCK rise
  always @(posedge sck) cap <= {cap[10:0], sdo};
  // Monitor: compare whatever the DUT presents against the scoreboard queues
  always @(negedge clk) begin
    if (frame_done) begin
      frames++;
      if (exp_q.size() == 0) chk("unexpected_frame_done", 32'(cap), 32'hFFFF_FFFF);
      else chk("frame_data", 32'(cap), 32'(exp_q.pop_front()));
    end
    if (cfg_valid) begin
      if (cfg_q.size() == 0) chk("unexpected_cfg_valid", 32'(cfg_word), 32'hFFFF_FFFF);
      else chk("cfg_word", 32'(cfg_word), 32'(cfg_q.pop_front()));
    end
  end
  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_convst();
    convst = 1'b1;
    clk_n(4);
    convst = 1'b0;
    clk_n(T + 6);
  endtask
  task automatic sck_bits(input logic [5:0] cfg, input int n);
    for (int i = 0; i < n; i++) begin
      sdi = (i < 6) ? cfg[5-i] : 1'b0;
      clk_n(4);
      sck = 1'b1;
      clk_n(4);
      sck = 1'b0;
    end
    clk_n(6);
  endtask
  task automatic frame(input logic [5:0] cfg, input logic [11:0] data);
    exp_q.push_back(data);
    cfg_q.push_back(cfg);
    frames_exp++;
    do_convst();
    sck_bits(cfg, 12);
  endtask
  initial begin
    int busy_n;
    logic bad_sdo, msb_seen, msb;
    clk_n(3);
    reset = 1'b0;
    clk_n(1);
    chk("reset_sdo", 32'(sdo), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_cfg_word", 32'(cfg_word), 0);
    chk("reset_pulses", 32'({cfg_valid, frame_done}), 0);
    // After reset UNI=0, so the first frame comes back with MSB flipped
    ch_data[0 +: 12]  = 12'hA5C;
    ch_data[60 +: 12] = 12'h123;
    frame(6'b100010, 12'h25C);
    frame(6'b100010, 12'hA5C);
    frame(6'b111010, 12'hA5C);
    frame(6'b100000, 12'h123);
    ch_data[0 +: 12] = 12'h7FF;
    frame(6'b100010, 12'hFFF);
    ch_data[0 +: 12] = 12'h800;
    frame(6'b100010, 12'h800);
    // UNI=0 proper: 100000 selects bipolar on the following conversions
    frame(6'b100000, 12'h800);
    frame(6'b100010, 12'h000);
    ch_data[0 +: 12] = 12'hABC;
    do_convst();
    sck_bits(6'b111111, 4);
    chk("abort_cfg_word", 32'(cfg_word), 32'(6'b100010));
    frame(6'b100010, 12'hABC);
    // CONVST and SCK activity during CONV must be ignored
    ch_data[0 +: 12] = 12'hC3A;
    busy_n = 0; bad_sdo = 1'b0; msb_seen = 1'b0; msb = 1'b0;
    exp_q.push_back(12'hC3A);
    cfg_q.push_back(6'b100010);
    frames_exp++;
    convst = 1'b1;
    for (int c = 0; c < T + 12; c++) begin
      @(negedge clk);
      if (c == 4) convst = 1'b0;
      if (c == 20) convst = 1'b1;
      if (c == 24) convst = 1'b0;
      sck = (c >= 8 && c < 40) ? c[2] : 1'b0;
      if (busy) begin
        busy_n++;
        if (sdo) bad_sdo = 1'b1;
      end else if (busy_n > 0 && !msb_seen) begin
        msb_seen = 1'b1;
        msb = sdo;
      end
    end
    chk("busy_cycles", 32'(busy_n), 32'(T));
    chk("sdo_low_in_conv", 32'(bad_sdo), 0);
    chk("msb_after_busy", 32'(msb), 1);
    sck_bits(6'b100010, 12);
    // Reset mid-frame after 7 rises: the sixth bit already completed a config word
    ch_data[0 +: 12] = 12'h456;
    cfg_q.push_back(6'b110110);
    do_convst();
    sck_bits(6'b110110, 7);
    reset = 1'b1;
    clk_n(1);
    reset = 1'b0;
    chk("midreset_sdo", 32'(sdo), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_cfg_word", 32'(cfg_word), 0);
    clk_n(4);
    frame(6'b100010, 12'hC56);
    clk_n(10);
    chk("frames_seen", 32'(frames), 32'(frames_exp));
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("cfg_q_empty", 32'(cfg_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
